// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM output head.
//   DEF_WIDTH / DEF_FRAC : default data width and fractional bits
//   fifo_entry_t         : one queued result {data, last}
//   sat_w                : clamps a wide signed value to a signed width
package lstm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 12;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] data;
    logic                        last;
  } fifo_entry_t;

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                               input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lstm_out_fifo.sv
// First-word-fall-through FIFO with a registered head.
//   clk, rst   : clock, asynchronous active-high reset
//   i_wr_en    : write request (accepted when not full, or when full and popping)
//   i_wr_data  : entry to write
//   i_rd_ready : consumer takes the head when the FIFO is not empty
//   o_rd_data  : registered head entry; holds its last value while empty
//   o_level    : number of stored entries
//   o_full     : level == DEPTH
//   o_empty    : level == 0 (the head is valid whenever this is low)
module lstm_out_fifo #(
  parameter int ENTRY_W = 17,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [ENTRY_W-1:0]         i_wr_data,
  input  logic                       i_rd_ready,
  output logic [ENTRY_W-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] CNT_MAX = LW'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_count;
  logic [ENTRY_W-1:0] r_head;

  logic               w_pop;
  logic               w_push;
  logic               w_bypass;
  logic [AW-1:0]      w_rd_nxt;
  logic [LW-1:0]      w_count_nxt;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_MAX);
  assign o_level   = r_count;
  assign o_rd_data = r_head;

  assign w_pop    = !o_empty && i_rd_ready;
  // A pop frees the slot the write needs, so a full FIFO still accepts.
  assign w_push   = i_wr_en && (!o_full || w_pop);
  assign w_rd_nxt = r_rd_ptr + AW'(w_pop);
  // The written entry becomes the head when nothing older survives this cycle.
  assign w_bypass = w_push && (o_empty || ((r_count == CNT_ONE) && w_pop));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      if (w_count_nxt != '0) r_head <= w_bypass ? i_wr_data : r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/lstm_output_head.sv
// Output head behind the final LSTM layer: out = sat(round(weight*y) + bias),
// tagged with sequence-end flags and buffered behind a valid/ready port.
//   clk, rst                    : clock, asynchronous active-high reset
//   weight/bias/seq_len (+valid): configuration, loaded on their strobes
//   last_only                   : 1 = keep only the last step of each sequence
//   y_in, y_in_valid            : sample stream, no backpressure
//   out_data/out_last/out_valid : FIFO head, popped by out_ready
//   overflow, overflow_clr      : sticky drop flag and its clear
//   level                       : FIFO occupancy
module lstm_output_head
  import lstm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       weight,
  input  logic                   weight_valid,
  input  logic [WIDTH-1:0]       bias,
  input  logic                   bias_valid,
  input  logic [SEQ_W-1:0]       seq_len,
  input  logic                   seq_len_valid,
  input  logic                   last_only,
  input  logic [WIDTH-1:0]       y_in,
  input  logic                   y_in_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PROD_W = 2 * WIDTH;
  // Two guard bits over the full product: rounding and bias never wrap.
  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam logic signed [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic [SEQ_W-1:0]        SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

  logic signed [WIDTH-1:0]  r_weight;
  logic signed [WIDTH-1:0]  r_bias;
  logic [SEQ_W-1:0]         r_seq_len;
  logic [SEQ_W-1:0]         r_step;
  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic                     r_overflow;
  logic signed [PROD_W-1:0] r_prod_p1;
  logic signed [WIDTH-1:0]  r_bias_p1;
  logic                     r_last_p1;
  logic                     r_keep_p1;
  logic [WIDTH-1:0]         r_data_p2;
  logic                     r_last_p2;
  logic                     r_keep_p2;

  logic [SEQ_W-1:0]         w_eff_len;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [63:0]       w_sum64;
  logic                     w_wr;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_drop;
  logic [WIDTH:0]           w_rd_data;

  assign w_eff_len = (r_seq_len == '0) ? SEQ_ONE : r_seq_len;
  assign w_last    = (r_step == (w_eff_len - SEQ_ONE));
  assign w_prod    = PROD_W'(r_weight) * PROD_W'($signed(y_in));

  assign w_rnd   = (ACC_W'(r_prod_p1) + HALF) >>> FRAC;
  assign w_sum   = w_rnd + ACC_W'(r_bias_p1);
  assign w_sum64 = 64'(w_sum);

  assign w_wr   = r_vld_p2 && r_keep_p2;
  assign w_drop = w_wr && w_full && !(out_valid && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weight   <= W_ONE;
      r_bias     <= '0;
      r_seq_len  <= SEQ_ONE;
      r_step     <= '0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (weight_valid) r_weight  <= weight;
      if (bias_valid)   r_bias    <= bias;
      if (seq_len_valid) begin
        r_seq_len <= seq_len;
        r_step    <= '0;
      end else if (y_in_valid) begin
        r_step <= w_last ? '0 : r_step + SEQ_ONE;
      end
      r_vld_p1 <= y_in_valid;
      r_vld_p2 <= r_vld_p1;
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // S1: product, sequence tag and the keep decision captured with the sample
    if (y_in_valid) begin
      r_prod_p1 <= w_prod;
      r_bias_p1 <= r_bias;
      r_last_p1 <= w_last;
      r_keep_p1 <= !last_only || w_last;
    end
    // S2: round half up, add bias, saturate
    if (r_vld_p1) begin
      r_data_p2 <= WIDTH'(sat_w(w_sum64, WIDTH));
      r_last_p2 <= r_last_p1;
      r_keep_p2 <= r_keep_p1;
    end
  end

  lstm_out_fifo #(
    .ENTRY_W (WIDTH + 1),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr),
    .i_wr_data  ({r_data_p2, r_last_p2}),
    .i_rd_ready (out_ready),
    .o_rd_data  (w_rd_data),
    .o_level    (level),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign out_data  = w_rd_data[WIDTH:1];
  assign out_last  = w_rd_data[0];
  assign out_valid = !w_empty;
  assign overflow  = r_overflow;

endmodule
